// File: rtl/button_debounce.sv
// button_debounce: per-bit synchronizer and stability-window debouncer for
// board push buttons. btn_out keeps the raw pin polarity. When the macro
// BUTTON_DEBOUNCE_PRESS_PULSE_EN is defined, press_pulse gives a one-cycle
// strobe per debounced press. Otherwise press_pulse is tied low.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TERMINAL = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CW-1:0]    count_q [WIDTH];
  logic [CW-1:0]    count_d [WIDTH];

  // Two-flop synchronizer; reset to the released level so no press is seen out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit window: any return to the stable level restarts the count; the terminal count commits
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i]  = count_q[i];
      stable_d[i] = stable_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        count_d[i] = '0;
      end else if (count_q[i] == TERMINAL) begin
        stable_d[i] = sync2_q[i];
        count_d[i]  = '0;
      end else begin
        count_d[i] = count_q[i] + CW'(1);
      end
    end
  end

  // Debounced level and window counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= RELEASED;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign btn_out = stable_q;

`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
  logic [WIDTH-1:0] stableDly_q;
  logic [WIDTH-1:0] pressPulse_q;
  logic [WIDTH-1:0] pressPulse_d;

  // A press is a bit that is now pressed but was released one cycle earlier
  always_comb begin
    pressPulse_d = (stable_q ^ RELEASED) & ~(stableDly_q ^ RELEASED);
  end

  // Strobe lands on the cycle after btn_out reaches the pressed level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stableDly_q  <= RELEASED;
      pressPulse_q <= '0;
    end else begin
      stableDly_q  <= stable_q;
      pressPulse_q <= pressPulse_d;
    end
  end

  assign press_pulse = pressPulse_q;
`else
  assign press_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench for button_debounce with WIDTH=4,
// DEBOUNCE_CYCLES=8 and ACTIVE_LOW=1. Expected press strobes follow
// BUTTON_DEBOUNCE_PRESS_PULSE_EN.
module tb_button_debounce;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;
  localparam int LAT   = 2 + DEB;

`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic [WIDTH-1:0] btn_in = 4'hF;
  logic [WIDTH-1:0] btn_out;
  logic [WIDTH-1:0] press_pulse;

  typedef struct {
    int         edgeNo;
    logic [3:0] expOut;
    logic [3:0] expPulse;
    string      name;
  } expect_t;

  typedef struct {
    logic [3:0] btnIn;
    logic [3:0] expBefore;
    logic [3:0] expAfter;
    logic [3:0] expPulse;
    string      name;
  } vector_t;

  expect_t sbQueue[$];
  expect_t curExp;
  vector_t vectors[7];
  int      testsRun    = 0;
  int      testsFailed = 0;
  int      edgeCount   = 0;

  button_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_out(btn_out),
    .press_pulse(press_pulse)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [3:0] pulseExp(input logic [3:0] p);
    return PULSE_EN ? p : 4'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actOut, input logic [3:0] actPulse,
                             input logic [3:0] expOut, input logic [3:0] expPulse);
    testsRun++;
    if (actOut !== expOut || actPulse !== expPulse) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: btn_out=%h press_pulse=%h, required btn_out=%h press_pulse=%h",
               name, edgeCount, actOut, actPulse, expOut, expPulse);
    end
  endtask

  // Scoreboard push, kept sorted by the edge at which the result is due
  task automatic expectAt(input int e, input logic [3:0] o, input logic [3:0] p, input string name);
    expect_t item;
    int      idx;
    item.edgeNo   = e;
    item.expOut   = o;
    item.expPulse = p;
    item.name     = name;
    idx = sbQueue.size();
    for (int k = 0; k < sbQueue.size(); k++) begin
      if (sbQueue[k].edgeNo > e) begin
        idx = k;
        break;
      end
    end
    sbQueue.insert(idx, item);
  endtask

  // Drive on the falling edge so the next rising edge is the first to sample
  task automatic applyStimulus(input logic [3:0] b);
    @(negedge clk);
    btn_in = b;
  endtask

  // One table row: level change, then checks around the expected commit edge
  task automatic runVector(input vector_t v);
    int e0;
    applyStimulus(v.btnIn);
    e0 = edgeCount;
    expectAt(e0 + LAT - 1, v.expBefore, 4'h0,              {v.name, "_before"});
    expectAt(e0 + LAT,     v.expAfter,  4'h0,              {v.name, "_commit"});
    expectAt(e0 + LAT + 1, v.expAfter,  pulseExp(v.expPulse), {v.name, "_pulse"});
    expectAt(e0 + LAT + 2, v.expAfter,  4'h0,              {v.name, "_pulse_end"});
    repeat (LAT + 4) @(negedge clk);
  endtask

  // Pop and compare every scoreboard entry due at this edge, sampled 1 ns after it
  always @(posedge clk) begin
    edgeCount++;
    #1;
    while (sbQueue.size() > 0 && sbQueue[0].edgeNo <= edgeCount) begin
      curExp = sbQueue.pop_front();
      checkOutput(curExp.name, btn_out, press_pulse, curExp.expOut, curExp.expPulse);
    end
  end

  initial begin
    int      g;
    int      f;
    int      r1;
    vector_t v;

    vectors[0] = '{4'hE, 4'hF, 4'hE, 4'h1, "press_b0"};
    vectors[1] = '{4'hF, 4'hE, 4'hF, 4'h0, "release_b0"};
    vectors[2] = '{4'h0, 4'hF, 4'h0, 4'hF, "press_all"};
    vectors[3] = '{4'hF, 4'h0, 4'hF, 4'h0, "release_all"};
    vectors[4] = '{4'h5, 4'hF, 4'h5, 4'hA, "press_b1b3"};
    vectors[5] = '{4'hA, 4'h5, 4'hA, 4'h5, "swap_pairs"};
    vectors[6] = '{4'hF, 4'hA, 4'hF, 4'h0, "release_b0b2"};

    reset  = 1'b1;
    btn_in = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", btn_out, press_pulse, 4'hF, 4'h0);
    reset = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      expectAt(edgeCount + 5 * k, 4'hF, 4'h0, "idle_released");
    end
    repeat (21) @(negedge clk);

    foreach (vectors[i]) begin
      runVector(vectors[i]);
    end

    applyStimulus(4'hD);
    g = edgeCount;
    repeat (4) @(negedge clk);
    applyStimulus(4'hF);
    applyStimulus(4'hD);
    f = edgeCount;
    expectAt(g + LAT,     4'hF, 4'h0,           "glitch_no_early_fall");
    expectAt(g + LAT + 1, 4'hF, 4'h0,           "glitch_no_early_pulse");
    expectAt(f + LAT - 1, 4'hF, 4'h0,           "glitch_before");
    expectAt(f + LAT,     4'hD, 4'h0,           "glitch_commit");
    expectAt(f + LAT + 1, 4'hD, pulseExp(4'h2), "glitch_pulse");
    expectAt(f + LAT + 2, 4'hD, 4'h0,           "glitch_pulse_end");
    repeat (LAT + 4) @(negedge clk);
    v = '{4'hF, 4'hD, 4'hF, 4'h0, "glitch_release"};
    runVector(v);

    applyStimulus(4'hE);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_mid_window", btn_out, press_pulse, 4'hF, 4'h0);
    reset = 1'b0;
    r1 = edgeCount;
    expectAt(r1 + LAT - 1, 4'hF, 4'h0,           "held_reset_before");
    expectAt(r1 + LAT,     4'hE, 4'h0,           "held_reset_commit");
    expectAt(r1 + LAT + 1, 4'hE, pulseExp(4'h1), "held_reset_pulse");
    expectAt(r1 + LAT + 2, 4'hE, 4'h0,           "held_reset_pulse_end");
    repeat (LAT + 4) @(negedge clk);
    v = '{4'hF, 4'hE, 4'hF, 4'h0, "held_reset_release"};
    runVector(v);

    for (int k = 0; k < 50 && sbQueue.size() > 0; k++) begin
      @(negedge clk);
    end
    if (sbQueue.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sbQueue.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
